dac_spi_tx: RTL and testbench

DAC_SPI_TX -- requirements
Module: dac_spi_tx

---
 rtl/dac_spi_tx.sv | 171 +++++++++++++++++
 tb/tb_dac_spi_tx.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_tx.sv
// SPI transmitter for a 12-bit DAC: shifts {0, BUF, 1x gain, active, sample}, then pulses LDAC.
// Optional feature: define DAC_PENDING_EN for a one-deep pending sample buffer.
module dac_spi_tx #(
   parameter int unsigned CLK_DIV = 2,
   parameter logic        BUF_BIT = 1'b0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [11:0] sample,
   input  logic        update,
   output logic        dac_sclk,
   output logic        dac_mosi,
   output logic        dac_cs_n,
   output logic        dac_ldac_n,
   output logic        busy,
   output logic        frame_done,
   output logic        overrun
);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CS_HI, S_LDAC} state_t;

   localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

   state_t      state_q;
   logic [7:0]  cnt_q;
   logic [3:0]  bit_q;
   logic [15:0] shift_q;
   logic        sclk_q, mosi_q, cs_n_q, ldac_n_q, busy_q, done_q, ovr_q;
   logic        start_d;
   logic [15:0] word_d;

   function automatic logic [15:0] frame_word(input logic [11:0] s);
      return {1'b0, BUF_BIT, 2'b11, s};
   endfunction

`ifdef DAC_PENDING_EN
   logic [11:0] pend_q;
   logic        pend_vld_q;
   logic        last_ldac;

   assign last_ldac = (state_q == S_LDAC) && (cnt_q == LAST);

   // A frame starts from idle, or back-to-back out of the last LDAC cycle.
   always_comb begin
      start_d = 1'b0;
      word_d  = frame_word(sample);
      if (state_q == S_IDLE && update) begin
         start_d = 1'b1;
      end else if (last_ldac && (pend_vld_q || update)) begin
         start_d = 1'b1;
         if (pend_vld_q) word_d = frame_word(pend_q);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_q     <= 12'h000;
         pend_vld_q <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         ovr_q <= 1'b0;
         if (update && state_q != S_IDLE) begin
            // An update in the last LDAC cycle with nothing pending goes straight out.
            if (!(last_ldac && !pend_vld_q)) begin
               pend_q     <= sample;
               pend_vld_q <= 1'b1;
               ovr_q      <= pend_vld_q && !last_ldac;
            end
         end else if (last_ldac) begin
            pend_vld_q <= 1'b0;
         end
      end
   end
`else
   always_comb begin
      start_d = (state_q == S_IDLE) && update;
      word_d  = frame_word(sample);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ovr_q <= 1'b0;
      else          ovr_q <= update && (state_q != S_IDLE);
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= 8'd0;
         bit_q    <= 4'd0;
         shift_q  <= 16'h0000;
         sclk_q   <= 1'b0;
         mosi_q   <= 1'b0;
         cs_n_q   <= 1'b1;
         ldac_n_q <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start_d) begin
            state_q  <= S_SHIFT;
            cnt_q    <= 8'd0;
            bit_q    <= 4'd0;
            shift_q  <= word_d;
            mosi_q   <= word_d[15];
            sclk_q   <= 1'b0;
            cs_n_q   <= 1'b0;
            ldac_n_q <= 1'b1;
            busy_q   <= 1'b1;
         end else begin
            case (state_q)
               S_SHIFT: begin
                  if (cnt_q != LAST) begin
                     cnt_q <= cnt_q + 8'd1;
                  end else begin
                     cnt_q <= 8'd0;
                     if (!sclk_q) begin
                        sclk_q <= 1'b1;
                     end else begin
                        // Data only moves on the falling edge, so it is stable at every rise.
                        sclk_q <= 1'b0;
                        if (bit_q == 4'd15) begin
                           cs_n_q  <= 1'b1;
                           mosi_q  <= 1'b0;
                           state_q <= S_CS_HI;
                        end else begin
                           bit_q   <= bit_q + 4'd1;
                           shift_q <= {shift_q[14:0], 1'b0};
                           mosi_q  <= shift_q[14];
                        end
                     end
                  end
               end
               S_CS_HI: begin
                  if (cnt_q != LAST) begin
                     cnt_q <= cnt_q + 8'd1;
                  end else begin
                     cnt_q    <= 8'd0;
                     ldac_n_q <= 1'b0;
                     state_q  <= S_LDAC;
                     done_q   <= (LAST == 8'd0);
                  end
               end
               S_LDAC: begin
                  if (cnt_q != LAST) begin
                     cnt_q  <= cnt_q + 8'd1;
                     done_q <= (({1'b0, cnt_q} + 9'd1) == {1'b0, LAST});
                  end else begin
                     cnt_q    <= 8'd0;
                     ldac_n_q <= 1'b1;
                     busy_q   <= 1'b0;
                     state_q  <= S_IDLE;
                  end
               end
               default: begin
                  cnt_q <= 8'd0;
               end
            endcase
         end
      end
   end

   assign dac_sclk   = sclk_q;
   assign dac_mosi   = mosi_q;
   assign dac_cs_n   = cs_n_q;
   assign dac_ldac_n = ldac_n_q;
   assign busy       = busy_q;
   assign frame_done = done_q;
   assign overrun    = ovr_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: CLK_DIV=2 and CLK_DIV=1 instances, frame/timing/reset checks.
module tb_dac_spi_tx;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [11:0] sample0, sample1;
   logic        update0, update1;
   logic        sclk0, mosi0, cs0, ldac0, busy0, fd0, ov0;
   logic        sclk1, mosi1, cs1, ldac1, busy1, fd1, ov1;

   always #5 clk = ~clk;

   dac_spi_tx #(.CLK_DIV(2), .BUF_BIT(1'b0)) u_dut (
      .clk(clk), .reset_n(reset_n), .sample(sample0), .update(update0),
      .dac_sclk(sclk0), .dac_mosi(mosi0), .dac_cs_n(cs0), .dac_ldac_n(ldac0),
      .busy(busy0), .frame_done(fd0), .overrun(ov0));

   dac_spi_tx #(.CLK_DIV(1), .BUF_BIT(1'b0)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .sample(sample1), .update(update1),
      .dac_sclk(sclk1), .dac_mosi(mosi1), .dac_cs_n(cs1), .dac_ldac_n(ldac1),
      .busy(busy1), .frame_done(fd1), .overrun(ov1));

   logic sel = 1'b0;
   wire  m_sclk = sel ? sclk1 : sclk0;
   wire  m_mosi = sel ? mosi1 : mosi0;
   wire  m_cs   = sel ? cs1   : cs0;
   wire  m_ldac = sel ? ldac1 : ldac0;
   wire  m_busy = sel ? busy1 : busy0;
   wire  m_fd   = sel ? fd1   : fd0;
   wire  m_ov   = sel ? ov1   : ov0;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   int          r_busy, r_first, r_last, r_gap, r_nbits, r_fd, r_fd_cyc;
   int          r_ov, r_ov_cyc, r_ldac, r_cshi, r_mosi_cs, r_mosi_chg, r_sclk_hi;
   logic [31:0] r_bits;

   // Updates are driven at negedges k==u0/u1/u2 (-1 = none); outputs sampled at every negedge.
   task automatic watch(input logic s, input int ncyc,
                        input int u0, input logic [11:0] s0,
                        input int u1, input logic [11:0] s1,
                        input int u2, input logic [11:0] s2);
      logic        p_sclk, p_mosi, upd;
      logic [11:0] smp;
      sel = s;
      r_busy = 0; r_first = -1; r_last = -1; r_gap = 0; r_nbits = 0; r_fd = 0;
      r_fd_cyc = -1; r_ov = 0; r_ov_cyc = -1; r_ldac = 0; r_cshi = 0;
      r_mosi_cs = 0; r_mosi_chg = 0; r_sclk_hi = 0; r_bits = 32'h0;
      p_sclk = 1'b0; p_mosi = 1'b0;
      for (int k = 0; k < ncyc; k++) begin
         @(negedge clk);
         if (m_busy) begin
            r_busy++;
            if (r_first < 0) r_first = k;
            else if (k != r_last + 1) r_gap++;
            r_last = k;
         end
         if (!p_sclk && m_sclk) begin
            r_bits = {r_bits[30:0], m_mosi};
            r_nbits++;
         end
         if (m_sclk) r_sclk_hi++;
         if (m_sclk && (m_mosi != p_mosi)) r_mosi_chg++;
         if (m_cs && m_mosi) r_mosi_cs++;
         if (m_fd) begin r_fd++; r_fd_cyc = k; end
         if (m_ov) begin r_ov++; r_ov_cyc = k; end
         if (!m_ldac) r_ldac++;
         if (m_cs && m_busy && m_ldac) r_cshi++;
         p_sclk = m_sclk;
         p_mosi = m_mosi;
         upd = (k == u0) || (k == u1) || (k == u2);
         smp = (k == u0) ? s0 : (k == u1) ? s1 : (k == u2) ? s2 : 12'($urandom);
         if (s) begin update1 = upd; sample1 = smp; end
         else   begin update0 = upd; sample0 = smp; end
      end
      @(negedge clk);
      update0 = 1'b0;
      update1 = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      update0 = 1'b0; update1 = 1'b0;
      sample0 = 12'h000; sample1 = 12'h000;
      repeat (3) @(negedge clk);
      chk("rst_sclk", 32'(sclk0), 32'd0);
      chk("rst_mosi", 32'(mosi0), 32'd0);
      chk("rst_cs_n", 32'(cs0), 32'd1);
      chk("rst_ldac_n", 32'(ldac0), 32'd1);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_done", 32'(fd0), 32'd0);
      chk("rst_ovr", 32'(ov0), 32'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single frame, sample 0xA5C
      watch(1'b0, 80, 0, 12'hA5C, -1, 12'h0, -1, 12'h0);
      chk("a5c_bits", r_bits[15:0], 32'h3A5C);
      chk("a5c_nbits", r_nbits, 16);
      chk("a5c_busy", r_busy, 68);
      chk("a5c_first", r_first, 1);
      chk("a5c_last", r_last, 68);
      chk("a5c_done", r_fd, 1);
      chk("a5c_done_cyc", r_fd_cyc, 68);
      chk("a5c_ldac", r_ldac, 2);
      chk("a5c_cshi", r_cshi, 2);
      chk("a5c_ovr", r_ov, 0);
      chk("a5c_mosi_stable", r_mosi_chg, 0);
      chk("a5c_mosi_cs", r_mosi_cs, 0);
      chk("a5c_sclk_hi", r_sclk_hi, 32);

      // Back-to-back frames, second accepted in the cycle busy drops
      watch(1'b0, 150, 0, 12'h000, 69, 12'hFFF, -1, 12'h0);
      chk("b2b_bits", r_bits, 32'h3000_3FFF);
      chk("b2b_nbits", r_nbits, 32);
      chk("b2b_busy", r_busy, 136);
      chk("b2b_last", r_last, 137);
      chk("b2b_gap", r_gap, 1);
      chk("b2b_done", r_fd, 2);
      chk("b2b_mosi_stable", r_mosi_chg, 0);

`ifdef DAC_PENDING_EN
      watch(1'b0, 150, 0, 12'hA5C, 10, 12'h111, 20, 12'h222);
      chk("pend_bits", r_bits, 32'h3A5C_3222);
      chk("pend_ovr", r_ov, 1);
      chk("pend_ovr_cyc", r_ov_cyc, 21);
      chk("pend_busy", r_busy, 136);
      chk("pend_gap", r_gap, 0);
      chk("pend_last", r_last, 136);
      chk("pend_done", r_fd, 2);
      chk("pend_ldac", r_ldac, 4);
`else
      watch(1'b0, 90, 0, 12'hA5C, 20, 12'h123, -1, 12'h0);
      chk("ovr_bits", r_bits[15:0], 32'h3A5C);
      chk("ovr_nbits", r_nbits, 16);
      chk("ovr_cnt", r_ov, 1);
      chk("ovr_cyc", r_ov_cyc, 21);
      chk("ovr_busy", r_busy, 68);
      chk("ovr_last", r_last, 68);
      chk("ovr_done", r_fd, 1);
`endif

      // Reset 20 cycles into a frame
      @(negedge clk);
      update0 = 1'b1; sample0 = 12'hA5C;
      @(negedge clk);
      update0 = 1'b0;
      repeat (19) @(negedge clk);
      chk("mid_busy_before", 32'(busy0), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("mid_cs_n", 32'(cs0), 32'd1);
      chk("mid_sclk", 32'(sclk0), 32'd0);
      chk("mid_ldac_n", 32'(ldac0), 32'd1);
      chk("mid_busy", 32'(busy0), 32'd0);
      chk("mid_mosi", 32'(mosi0), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      watch(1'b0, 80, -1, 12'h0, -1, 12'h0, -1, 12'h0);
      chk("post_rst_busy", r_busy, 0);
      chk("post_rst_ldac", r_ldac, 0);
      chk("post_rst_done", r_fd, 0);

      // CLK_DIV=1 instance
      watch(1'b1, 45, 0, 12'h800, -1, 12'h0, -1, 12'h0);
      chk("div1_bits", r_bits[15:0], 32'h3800);
      chk("div1_nbits", r_nbits, 16);
      chk("div1_busy", r_busy, 34);
      chk("div1_last", r_last, 34);
      chk("div1_sclk_hi", r_sclk_hi, 16);
      chk("div1_done_cyc", r_fd_cyc, 34);
      chk("div1_ldac", r_ldac, 1);
      chk("div1_cshi", r_cshi, 1);
      chk("div1_mosi_stable", r_mosi_chg, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
